// File: rtl/result_unloader.sv
// result_unloader
//
// Drains the pairing result from the operand RAM after the command sequencer
// finishes. A one-cycle `start` (the sequencer's `done`) kicks off NUM_WORDS
// reads starting at BASE_ADDR. Each DATA_W-bit word is streamed LSB-first as
// OUT_W-bit chunks on a valid/ready interface. The last chunk of a word is
// zero-padded above the DATA_W mod OUT_W valid bits.
//
// Optional feature: define RESULT_UNLOAD_LAST_EN to drive out_last on the
// final chunk of the final word; otherwise out_last is tied low.
//
// Ports:
//   clk         in   clock, posedge
//   reset       in   synchronous, active-high
//   start       in   one-cycle start strobe, ignored unless idle
//   ram_addr    out  RAM read address, 0 outside READ
//   ram_rd      out  high in READ; selects this block onto the shared RAM port
//   ram_q       in   RAM read data, valid one cycle after ram_addr
//   out_data    out  current chunk, 0 outside SEND
//   out_valid   out  chunk valid
//   out_ready   in   consumer accepts the chunk
//   out_last    out  final chunk of final word (RESULT_UNLOAD_LAST_EN only)
//   busy        out  high in every state except IDLE
//   unload_done out  one-cycle pulse when the unload completes

module result_unloader #(
  parameter int unsigned           DATA_W    = 194,
  parameter int unsigned           OUT_W     = 32,
  parameter int unsigned           ADDR_W    = 6,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = 6'd18,
  parameter int unsigned           NUM_WORDS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              unload_done
);

  localparam int unsigned CHUNKS = (DATA_W + OUT_W - 1) / OUT_W;
  localparam int unsigned ChunkW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned WordW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  // Shift register is padded to a whole number of chunks so the final chunk
  // of each word is naturally zero-filled above the valid bits.
  localparam int unsigned ShiftW = CHUNKS * OUT_W;

  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(CHUNKS - 1);
  localparam logic [WordW-1:0]  LastWord  = WordW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StSend,
    StFin
  } state_e;

  state_e              state_q;
  logic [WordW-1:0]    word_q;
  logic [ChunkW-1:0]   chunk_q;
  logic [ShiftW-1:0]   shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      chunk_q <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StRead;
        end
        StRead: begin
          state_q <= StLoad;
        end
        StLoad: begin
          shift_q <= ShiftW'(ram_q);
          chunk_q <= '0;
          state_q <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            shift_q <= shift_q >> OUT_W;
            chunk_q <= chunk_q + ChunkW'(1);
            if (chunk_q == LastChunk) begin
              if (word_q == LastWord) begin
                state_q <= StFin;
              end else begin
                word_q  <= word_q + WordW'(1);
                state_q <= StRead;
              end
            end
          end
        end
        StFin: begin
          word_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; nothing depends on out_ready.
  assign ram_rd      = (state_q == StRead);
  assign ram_addr    = ram_rd ? (BASE_ADDR + ADDR_W'(word_q)) : '0;
  assign out_valid   = (state_q == StSend);
  assign out_data    = out_valid ? shift_q[OUT_W-1:0] : '0;
  assign busy        = (state_q != StIdle);
  assign unload_done = (state_q == StFin);

`ifdef RESULT_UNLOAD_LAST_EN
  assign out_last = out_valid && (word_q == LastWord) && (chunk_q == LastChunk);
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;

  localparam int DW     = 194;
  localparam int OW     = 32;
  localparam int NW     = 6;
  localparam int CH     = 7;
  localparam int TOTAL  = NW * CH;
  localparam int BASE   = 18;
`ifdef RESULT_UNLOAD_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    ram_addr;
  logic          ram_rd;
  logic [DW-1:0] ram_q = '0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          unload_done;

  logic          w_start = 1'b0;
  logic [5:0]    w_ram_addr;
  logic          w_ram_rd;
  logic [DW-1:0] w_ram_q = '0;
  logic [OW-1:0] w_out_data;
  logic          w_out_valid;
  logic          w_out_ready = 1'b1;
  logic          w_out_last;
  logic          w_busy;
  logic          w_unload_done;

  logic [DW-1:0] ram [64];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q   <= ram[ram_addr];
  always @(posedge clk) w_ram_q <= ram[w_ram_addr];

  result_unloader u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_q       (ram_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .unload_done (unload_done)
  );

  result_unloader #(
    .BASE_ADDR (6'd62),
    .NUM_WORDS (3)
  ) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .start       (w_start),
    .ram_addr    (w_ram_addr),
    .ram_rd      (w_ram_rd),
    .ram_q       (w_ram_q),
    .out_data    (w_out_data),
    .out_valid   (w_out_valid),
    .out_ready   (w_out_ready),
    .out_last    (w_out_last),
    .busy        (w_busy),
    .unload_done (w_unload_done)
  );

  typedef struct {
    int         cyc;
    logic       busy;
    logic       valid;
    logic       rd;
    logic [5:0] addr;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [CH*OW-1:0] w;
    for (int i = 0; i < CH; i++) w[i*OW +: OW] = $urandom;
    return w[DW-1:0];
  endfunction

  // Reference: chunk c of a word is bits [32c +: 32] with zero fill above bit 193.
  function automatic logic [OW-1:0] ref_chunk(input logic [DW-1:0] w, input int c);
    logic [DW-1:0] s;
    s = w >> (OW * c);
    return s[OW-1:0];
  endfunction

  task automatic fill_ram();
    for (int i = 0; i < 64; i++) ram[i] = rnd_word();
  endtask

  task automatic do_unload(input int pct, input bit poke_start, input bit use_table,
                           input string tag);
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] prev_data = '0;
    bit            prev_stall = 1'b0;
    int            got = 0;
    int            dones = 0;
    int            t = 0;
    bit            ended = 1'b0;
    for (int w = 0; w < NW; w++)
      for (int c = 0; c < CH; c++) exp_q.push_back(ref_chunk(ram[(BASE + w) % 64], c));
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (t < 3000) begin
      if (use_table)
        foreach (vecs[i])
          if (vecs[i].cyc == t) begin
            check({tag, " busy"},  64'(busy),        64'(vecs[i].busy));
            check({tag, " valid"}, 64'(out_valid),   64'(vecs[i].valid));
            check({tag, " rd"},    64'(ram_rd),      64'(vecs[i].rd));
            check({tag, " addr"},  64'(ram_addr),    64'(vecs[i].addr));
            check({tag, " done"},  64'(unload_done), 64'(vecs[i].done));
          end
      if (unload_done) dones++;
      if (prev_stall) begin
        check({tag, " stall valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " stall data"},  64'(out_data),  64'(prev_data));
      end
      check({tag, " last"}, 64'(out_last), 64'(LastEn && out_valid && got == TOTAL - 1));
      if (!busy && t > 0) begin
        ended = 1'b1;
        break;
      end
      out_ready = (int'($urandom_range(99)) < pct);
      start = poke_start && (t == 20);
      if (out_valid && out_ready) begin
        if (got < TOTAL) check({tag, " chunk"}, 64'(out_data), 64'(exp_q[got]));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      t++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check({tag, " finished"}, 64'(ended), 64'(1'b1));
    check({tag, " chunk count"}, 64'(got), 64'(TOTAL));
    check({tag, " done pulses"}, 64'(dones), 64'(1));
    if (use_table) check({tag, " length"}, 64'(t), 64'(55));
  endtask

  initial begin
    vecs.push_back('{cyc: 0,  busy: 1, valid: 0, rd: 1, addr: 6'd18, done: 0});
    vecs.push_back('{cyc: 1,  busy: 1, valid: 0, rd: 0, addr: 6'd0,  done: 0});
    vecs.push_back('{cyc: 2,  busy: 1, valid: 1, rd: 0, addr: 6'd0,  done: 0});
    vecs.push_back('{cyc: 8,  busy: 1, valid: 1, rd: 0, addr: 6'd0,  done: 0});
    vecs.push_back('{cyc: 9,  busy: 1, valid: 0, rd: 1, addr: 6'd19, done: 0});
    vecs.push_back('{cyc: 10, busy: 1, valid: 0, rd: 0, addr: 6'd0,  done: 0});
    vecs.push_back('{cyc: 45, busy: 1, valid: 0, rd: 1, addr: 6'd23, done: 0});
    vecs.push_back('{cyc: 53, busy: 1, valid: 1, rd: 0, addr: 6'd0,  done: 0});
    vecs.push_back('{cyc: 54, busy: 1, valid: 0, rd: 0, addr: 6'd0,  done: 1});
    vecs.push_back('{cyc: 55, busy: 0, valid: 0, rd: 0, addr: 6'd0,  done: 0});

    fill_ram();
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check("reset busy",  64'(busy),        64'(0));
    check("reset valid", 64'(out_valid),   64'(0));
    check("reset data",  64'(out_data),    64'(0));
    check("reset rd",    64'(ram_rd),      64'(0));
    check("reset addr",  64'(ram_addr),    64'(0));
    check("reset last",  64'(out_last),    64'(0));
    check("reset done",  64'(unload_done), 64'(0));
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle busy", 64'(busy), 64'(0));

    do_unload(100, 1'b0, 1'b1, "basic");
    do_unload(30, 1'b0, 1'b0, "bp1");
    fill_ram();
    do_unload(30, 1'b0, 1'b0, "bp2");
    do_unload(100, 1'b1, 1'b1, "restart");

    // Reset after the tenth accepted chunk, then replay from the first word.
    begin
      int got = 0;
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 200 && got < 10; t++) begin
        if (out_valid) got++;
        tick();
      end
      check("mid chunks", 64'(got), 64'(10));
      reset = 1'b1;
      out_ready = 1'b0;
      tick();
      check("mid reset busy",  64'(busy),      64'(0));
      check("mid reset valid", 64'(out_valid), 64'(0));
      check("mid reset data",  64'(out_data),  64'(0));
      check("mid reset rd",    64'(ram_rd),    64'(0));
      reset = 1'b0;
      tick();
      do_unload(100, 1'b0, 1'b1, "replay");
    end

    // Address wrap on the second instance: base 62, three words.
    begin
      logic [5:0]    addrs[$];
      logic [5:0]    exp_addr[3] = '{6'd62, 6'd63, 6'd0};
      logic [OW-1:0] wexp[$];
      int            wgot = 0;
      for (int w = 0; w < 3; w++)
        for (int c = 0; c < CH; c++) wexp.push_back(ref_chunk(ram[(62 + w) % 64], c));
      w_start = 1'b1;
      tick();
      w_start = 1'b0;
      for (int t = 0; t < 300; t++) begin
        if (w_ram_rd) addrs.push_back(w_ram_addr);
        if (w_out_valid) begin
          if (wgot < 3 * CH) check("wrap chunk", 64'(w_out_data), 64'(wexp[wgot]));
          check("wrap last", 64'(w_out_last), 64'(LastEn && wgot == 3 * CH - 1));
          wgot++;
        end
        if (!w_busy) break;
        tick();
      end
      check("wrap busy", 64'(w_busy), 64'(0));
      check("wrap reads", 64'(addrs.size()), 64'(3));
      for (int i = 0; i < 3 && i < addrs.size(); i++)
        check("wrap addr", 64'(addrs[i]), 64'(exp_addr[i]));
      check("wrap chunk count", 64'(wgot), 64'(3 * CH));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
